mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Memory access controller sitting directly upstream of the byte-wide RAM. It arbitrates between the instruction-fetch client (16-bit reads) and the data client (8-bit read/write). It sequences the RAM read/write strobes and waits on the RAM ready handshakes. It assembles 16-bit instruction words from two byte reads and returns results with a one-cycle ack pulse.

Parameters:
size_addr, 8, width of all byte addresses
timeout, 15, max cycles waited for ram_ready_r/ram_ready_w before aborting with error (1..255)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
if_req  input  1  fetch request, level
if_addr  input  size_addr  fetch byte address (low byte of word)
if_ack  output  1  one-cycle pulse: fetch complete
if_data  output  16  fetched word {mem[a+1], mem[a]}
if_err  output  1  valid with if_ack: fetch timed out
d_req  input  1  data request, level
d_we  input  1  1 = write, 0 = read
d_addr  input  size_addr  data byte address
d_wdata  input  8  write data
d_ack  output  1  one-cycle pulse: data access complete
d_rdata  output  8  read data, valid from d_ack onward
d_err  output  1  valid with d_ack: access timed out
ram_read  output  1  RAM read strobe
ram_write  output  1  RAM write strobe
ram_addr  output  size_addr  RAM address
ram_wdata  output  8  RAM write data
ram_rdata  input  8  RAM read data, valid in ram_ready_r cycle
ram_ready_r  input  1  RAM read done
ram_ready_w  input  1  RAM write done

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = FETCH, so data wins the first tie; wait counter 0.
- Reset mid-transaction aborts it immediately. No ack is issued, and strobes drop in the next cycle.
- States: IDLE, I_LO_REQ, I_LO_WAIT, I_HI_REQ, I_HI_WAIT, D_REQ, D_WAIT, DONE.
- IDLE: samples d_req/if_req.
  - If only one is high, grant it.
  - If both are high, grant the client not in last_grant, then update last_grant.
  - On grant, latch address, d_we and d_wdata into internal registers. Client inputs are don't-care after the grant cycle.
- *_REQ states: assert exactly one strobe for exactly one cycle.
  - ram_read for reads and fetch bytes; ram_write for writes.
  - ram_addr/ram_wdata come from the latched values and are held stable through the following WAIT state.
  - Strobes are registered outputs.
- *_WAIT states: the counter increments each cycle.
  - Ready seen (ram_ready_r for reads, ram_ready_w for writes): capture ram_rdata if reading, clear the counter, advance.
  - Counter reaches timeout with no ready: go to DONE with err=1. Captured data is undefined for the missing bytes.
- I_LO_WAIT on ready: capture the low byte, go to I_HI_REQ.
  - High address = latched address + 1, modulo 2^size_addr, so 0xFF wraps to 0x00.
- I_HI_WAIT on ready: capture the high byte. D_WAIT on ready: capture d_rdata if reading.
- DONE: pulse the granted client's ack for one cycle with its err flag, then return to IDLE.
  - Err is 0 on success.
  - if_data/d_rdata hold their value until the next completion of the same client.
- Latency from req-sampled cycle to ack, with a RAM answering one cycle after the strobe:
  - data: 4 cycles (IDLE, D_REQ, D_WAIT, DONE)
  - fetch: 6 cycles
- A req still high in the cycle after ack is a new request. Back-to-back accesses are allowed with one IDLE cycle between them.
- Ready pulses arriving outside the matching WAIT state are ignored, and neither ready type advances the other's WAIT state.
- No ack is ever issued to a client that is not granted. Only one transaction is in flight at a time.

Test Plan:
- Data path: write d_addr=0x10, d_wdata=0xA5, then read 0x10 -> ram_write high for one cycle with addr 0x10; d_ack at cycle 4; d_rdata=0xA5, d_err=0.
- Fetch wrap: RAM preloaded mem[0xFF]=0x34, mem[0x00]=0x12; fetch 0xFF -> ram_addr 0xFF then 0x00; if_ack at cycle 6; if_data=0x1234.
- Arbitration: if_req and d_req held high together from reset -> grants alternate data, fetch, data, fetch; each client acked in turn.
- Reset mid-fetch: assert reset during I_HI_WAIT -> next cycle all outputs 0, no if_ack; a fresh fetch afterwards completes normally.
- Timeout: RAM model never asserts ram_ready_r on a data read, timeout=15 -> d_ack with d_err=1 after 15 wait cycles; the following access succeeds.
- Stray ready: pulse ram_ready_w while in I_LO_WAIT and ram_ready_r in IDLE -> state unchanged, no ack, no captured data.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory access controller: arbitrates a 16-bit instruction fetch client and an
// 8-bit data client onto a byte-wide RAM using strobe/ready handshakes with a wait timeout.
//
// state     | meaning
// IDLE      | arbitrate d_req / if_req, latch the granted request
// I_LO_REQ  | read strobe for the fetch low byte
// I_LO_WAIT | wait for ram_ready_r on the low byte
// I_HI_REQ  | read strobe for the fetch high byte (address + 1, wrapping)
// I_HI_WAIT | wait for ram_ready_r on the high byte
// D_REQ     | read or write strobe for the data access
// D_WAIT    | wait for ram_ready_r (read) or ram_ready_w (write)
// DONE      | one-cycle ack (with err) to the granted client
module mem_ctrl #(
   parameter int size_addr = 8,
   parameter int timeout   = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_req,
   input  logic [size_addr-1:0] if_addr,
   output logic                 if_ack,
   output logic [15:0]          if_data,
   output logic                 if_err,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [size_addr-1:0] d_addr,
   input  logic [7:0]           d_wdata,
   output logic                 d_ack,
   output logic [7:0]           d_rdata,
   output logic                 d_err,
   output logic                 ram_read,
   output logic                 ram_write,
   output logic [size_addr-1:0] ram_addr,
   output logic [7:0]           ram_wdata,
   input  logic [7:0]           ram_rdata,
   input  logic                 ram_ready_r,
   input  logic                 ram_ready_w
);

   typedef enum logic [2:0] {
      IDLE,
      I_LO_REQ,
      I_LO_WAIT,
      I_HI_REQ,
      I_HI_WAIT,
      D_REQ,
      D_WAIT,
      DONE
   } state_t;

   localparam logic [7:0]           WAIT_LAST = 8'(timeout - 1);
   localparam logic [size_addr-1:0] ADDR_ONE  = size_addr'(1);

   state_t     state;
   state_t     state_nxt;
   // Doubles as the current-transaction owner and the arbitration history.
   logic       last_fetch;
   logic       we_q;
   logic [7:0] lo_q;
   logic [7:0] wait_cnt;

   logic take_fetch;
   logic take_data;
   logic lo_hit;
   logic hi_hit;
   logic d_hit;
   logic timed_out;
   logic in_wait;
   logic wait_last;
   logic enter_done;

   assign in_wait    = (state == I_LO_WAIT) || (state == I_HI_WAIT) || (state == D_WAIT);
   assign wait_last  = (wait_cnt == WAIT_LAST);
   assign enter_done = (state_nxt == DONE);

   always_comb begin
      state_nxt  = state;
      take_fetch = 1'b0;
      take_data  = 1'b0;
      lo_hit     = 1'b0;
      hi_hit     = 1'b0;
      d_hit      = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && (!if_req || last_fetch)) begin
               take_data = 1'b1;
               state_nxt = D_REQ;
            end else if (if_req) begin
               take_fetch = 1'b1;
               state_nxt  = I_LO_REQ;
            end
         end
         I_LO_REQ: state_nxt = I_LO_WAIT;
         I_LO_WAIT: begin
            if (ram_ready_r) begin
               lo_hit    = 1'b1;
               state_nxt = I_HI_REQ;
            end else if (wait_last) begin
               timed_out = 1'b1;
               state_nxt = DONE;
            end
         end
         I_HI_REQ: state_nxt = I_HI_WAIT;
         I_HI_WAIT: begin
            if (ram_ready_r) begin
               hi_hit    = 1'b1;
               state_nxt = DONE;
            end else if (wait_last) begin
               timed_out = 1'b1;
               state_nxt = DONE;
            end
         end
         D_REQ: state_nxt = D_WAIT;
         D_WAIT: begin
            if (we_q ? ram_ready_w : ram_ready_r) begin
               d_hit     = 1'b1;
               state_nxt = DONE;
            end else if (wait_last) begin
               timed_out = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_fetch <= 1'b1;
         we_q       <= 1'b0;
         lo_q       <= 8'd0;
         wait_cnt   <= 8'd0;
         ram_read   <= 1'b0;
         ram_write  <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= 8'd0;
         if_ack     <= 1'b0;
         if_err     <= 1'b0;
         if_data    <= 16'd0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= 8'd0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= (in_wait && (state_nxt == state)) ? wait_cnt + 8'd1 : 8'd0;
         ram_read  <= take_fetch | (take_data & ~d_we) | lo_hit;
         ram_write <= take_data & d_we;
         if_ack    <= enter_done & last_fetch;
         if_err    <= enter_done & last_fetch & timed_out;
         d_ack     <= enter_done & ~last_fetch;
         d_err     <= enter_done & ~last_fetch & timed_out;

         // ram_addr itself is the latched request address for the whole transaction.
         if (take_fetch) begin
            last_fetch <= 1'b1;
            ram_addr   <= if_addr;
         end
         if (take_data) begin
            last_fetch <= 1'b0;
            ram_addr   <= d_addr;
            ram_wdata  <= d_wdata;
            we_q       <= d_we;
         end
         if (lo_hit) begin
            lo_q     <= ram_rdata;
            ram_addr <= ram_addr + ADDR_ONE;
         end
         if (hi_hit) begin
            if_data <= {ram_rdata, lo_q};
         end
         if (d_hit && !we_q) begin
            d_rdata <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: RAM model with programmable ready latency, a transaction-level
// timeline model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_ctrl;

   localparam int T = 15;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        if_ack;
   logic [15:0] if_data;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [7:0]  d_addr;
   logic [7:0]  d_wdata;
   logic        d_ack;
   logic [7:0]  d_rdata;
   logic        d_err;
   logic        ram_read;
   logic        ram_write;
   logic [7:0]  ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        ram_ready_r;
   logic        ram_ready_w;

   logic        rdy_r_m;
   logic        rdy_w_m;
   logic [7:0]  rdata_m;
   logic        stray_r;
   logic        stray_w;

   assign ram_ready_r = rdy_r_m | stray_r;
   assign ram_ready_w = rdy_w_m | stray_w;
   assign ram_rdata   = stray_r ? 8'hEE : rdata_m;

   mem_ctrl #(.size_addr(8), .timeout(T)) dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_ack     (if_ack),
      .if_data    (if_data),
      .if_err     (if_err),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .d_err      (d_err),
      .ram_read   (ram_read),
      .ram_write  (ram_write),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .ram_ready_r(ram_ready_r),
      .ram_ready_w(ram_ready_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // RAM model: answers ram_lat cycles after a strobe, never answers when muted.
   logic [7:0] ram_mem [256];
   int         ram_lat  = 1;
   bit         ram_mute = 1'b0;
   int         rd_cd    = 0;
   int         wr_cd    = 0;
   logic [7:0] rd_a;

   always @(negedge clk) begin
      rdy_r_m = 1'b0;
      rdy_w_m = 1'b0;
      if (reset) begin
         rd_cd = 0;
         wr_cd = 0;
      end else begin
         if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
               rdy_r_m = !ram_mute;
               rdata_m = ram_mem[rd_a];
            end
         end
         if (wr_cd > 0) begin
            wr_cd--;
            if (wr_cd == 0) rdy_w_m = !ram_mute;
         end
         if (ram_read) begin
            rd_cd = ram_lat;
            rd_a  = ram_addr;
         end
         if (ram_write) begin
            wr_cd = ram_lat;
            ram_mem[ram_addr] = ram_wdata;
         end
      end
   end

   // Transaction model: on each grant, derive the whole cycle timeline arithmetically.
   logic [7:0]  ref_mem [256];
   int          cyc = 0;
   int          next_free = 0;
   bit          act = 1'b0;
   bit          m_fetch, m_we, m_err, m_ok;
   logic [7:0]  m_addr, m_wdata, m_addr_hi;
   int          m_s = 0, m_hi = -1, m_done = 0;
   bit          last_fetch = 1'b1;
   logic [15:0] cur_if = 16'd0;
   logic [7:0]  cur_d  = 8'd0;
   bit          if_known = 1'b1, d_known = 1'b1;

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         act        = 1'b0;
         last_fetch = 1'b1;
         next_free  = cyc + 1;
         cur_if     = 16'd0;
         cur_d      = 8'd0;
         if_known   = 1'b1;
         d_known    = 1'b1;
      end else begin
         if (act && cyc == m_done) begin
            if (m_fetch) begin
               m_addr_hi = m_addr + 8'd1;
               if (!m_err) cur_if = {ref_mem[m_addr_hi], ref_mem[m_addr]};
               if_known = !m_err;
            end else if (m_we) begin
               if (!m_err) ref_mem[m_addr] = m_wdata;
            end else begin
               if (!m_err) cur_d = ref_mem[m_addr];
               d_known = !m_err;
            end
         end
         if (cyc >= next_free && (if_req || d_req)) begin
            m_fetch    = (if_req && d_req) ? !last_fetch : if_req;
            last_fetch = m_fetch;
            m_addr     = m_fetch ? if_addr : d_addr;
            m_we       = !m_fetch && d_we;
            m_wdata    = d_wdata;
            m_s        = cyc;
            m_ok       = !ram_mute && ram_lat <= T;
            if (m_fetch && m_ok) begin
               m_hi   = m_s + ram_lat + 1;
               m_done = m_hi + ram_lat + 1;
            end else begin
               m_hi   = -1;
               m_done = m_ok ? m_s + ram_lat + 1 : m_s + T + 1;
            end
            m_err     = !m_ok;
            act       = 1'b1;
            next_free = m_done + 2;
         end
      end
   end

   logic [7:0] exp_addr;
   bit         at_done;

   always @(negedge clk) begin
      if (cyc > 0) begin
         at_done = act && cyc == m_done;
         check("if_ack", if_ack, at_done && m_fetch);
         check("if_err", if_err, at_done && m_fetch && m_err);
         check("d_ack", d_ack, at_done && !m_fetch);
         check("d_err", d_err, at_done && !m_fetch && m_err);
         check("ram_read", ram_read, act && ((cyc == m_s && !m_we) || cyc == m_hi));
         check("ram_write", ram_write, act && cyc == m_s && m_we);
         if (act && cyc >= m_s && cyc < m_done) begin
            exp_addr = (m_fetch && m_hi >= 0 && cyc >= m_hi) ? m_addr + 8'd1 : m_addr;
            check("ram_addr", ram_addr, exp_addr);
            if (m_we) check("ram_wdata", ram_wdata, m_wdata);
         end
         if (if_known) check("if_data", if_data, cur_if);
         if (d_known) check("d_rdata", d_rdata, cur_d);
      end
   end

   task automatic run_data(input logic we, input logic [7:0] a, input logic [7:0] wd,
                           output int n, output logic err, output logic [7:0] rd,
                           output int nwr, output logic [7:0] waddr);
      bit got;
      @(negedge clk);
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      n = 1; got = 1'b0; err = 1'b0; rd = 8'd0; nwr = 0; waddr = 8'd0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 2) begin
            d_req = 1'b0; d_we = ~we; d_addr = ~a; d_wdata = ~wd;
         end
         if (ram_write) begin
            nwr++;
            waddr = ram_addr;
         end
         if (d_ack) begin
            got = 1'b1; err = d_err; rd = d_rdata;
         end
      end
      check("d_ack_seen", got, 1);
   endtask

   task automatic run_fetch(input logic [7:0] a, input int stray_at,
                            output int n, output logic err, output logic [15:0] data,
                            output logic [7:0] a0, output logic [7:0] a1);
      bit got;
      int nrd;
      @(negedge clk);
      if_req = 1'b1; if_addr = a;
      n = 1; got = 1'b0; err = 1'b0; data = 16'd0; a0 = 8'd0; a1 = 8'd0; nrd = 0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (n == 2) begin
            if_req = 1'b0; if_addr = ~a;
         end
         stray_w = (n == stray_at);
         if (ram_read) begin
            if (nrd == 0) a0 = ram_addr;
            else a1 = ram_addr;
            nrd++;
         end
         if (if_ack) begin
            got = 1'b1; err = if_err; data = if_data;
         end
      end
      stray_w = 1'b0;
      check("if_ack_seen", got, 1);
   endtask

   int          n, nwr, acks, nack;
   logic        err;
   logic [7:0]  rd, waddr, a0, a1;
   logic [15:0] fd;
   logic [3:0]  order;

   initial begin
      reset = 1'b1; if_req = 1'b0; if_addr = 8'd0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 8'd0; d_wdata = 8'd0; stray_r = 1'b0; stray_w = 1'b0;
      rdata_m = 8'd0;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      ram_mem[8'hFF] = 8'h34; ref_mem[8'hFF] = 8'h34;
      ram_mem[8'h00] = 8'h12; ref_mem[8'h00] = 8'h12;

      repeat (3) @(negedge clk);
      check("rst_ram_read", ram_read, 0);
      check("rst_ram_write", ram_write, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_if_data", if_data, 0);
      check("rst_d_rdata", d_rdata, 0);
      reset = 1'b0;

      run_data(1'b1, 8'h10, 8'hA5, n, err, rd, nwr, waddr);
      check("wr_latency", n, 4);
      check("wr_err", err, 0);
      check("wr_strobes", nwr, 1);
      check("wr_addr", waddr, 8'h10);
      run_data(1'b0, 8'h10, 8'h00, n, err, rd, nwr, waddr);
      check("rd_latency", n, 4);
      check("rd_data", rd, 8'hA5);
      check("rd_err", err, 0);
      run_data(1'b1, 8'h11, 8'h3C, n, err, rd, nwr, waddr);
      run_data(1'b0, 8'h11, 8'h00, n, err, rd, nwr, waddr);
      check("rd11_data", rd, 8'h3C);
      ram_lat = 2;
      run_data(1'b0, 8'h10, 8'h00, n, err, rd, nwr, waddr);
      check("rd_lat2_latency", n, 5);
      check("rd_lat2_data", rd, 8'hA5);
      ram_lat = 1;

      run_fetch(8'hFF, 0, n, err, fd, a0, a1);
      check("fetch_latency", n, 6);
      check("fetch_wrap_data", fd, 16'h1234);
      check("fetch_addr_lo", a0, 8'hFF);
      check("fetch_addr_hi", a1, 8'h00);
      check("fetch_err", err, 0);

      @(negedge clk); stray_r = 1'b1;
      @(negedge clk); stray_r = 1'b0;
      repeat (2) @(negedge clk);
      check("stray_r_idle_hold", d_rdata, 8'hA5);
      check("stray_r_idle_no_strobe", ram_read, 0);

      ram_lat = 3;
      run_fetch(8'h40, 3, n, err, fd, a0, a1);
      check("stray_w_fetch_latency", n, 10);
      check("stray_w_fetch_data", fd, 16'hCAC3);
      ram_lat = 1;

      ram_mute = 1'b1;
      run_data(1'b0, 8'h10, 8'h00, n, err, rd, nwr, waddr);
      check("timeout_latency", n, 18);
      check("timeout_err", err, 1);
      ram_mute = 1'b0;
      run_data(1'b0, 8'h11, 8'h00, n, err, rd, nwr, waddr);
      check("post_timeout_latency", n, 4);
      check("post_timeout_data", rd, 8'h3C);
      check("post_timeout_err", err, 0);

      // Reset lands in I_HI_WAIT (cycle 5 of a 6-cycle fetch).
      acks = 0;
      @(negedge clk); if_req = 1'b1; if_addr = 8'h20; n = 1;
      repeat (4) begin
         @(negedge clk); n++;
         if (n == 2) begin if_req = 1'b0; if_addr = 8'h99; end
         if (if_ack) acks++;
      end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_ram_read", ram_read, 0);
      check("midrst_ram_addr", ram_addr, 0);
      check("midrst_if_ack", if_ack, 0);
      check("midrst_if_data", if_data, 0);
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (if_ack) acks++;
      end
      check("midrst_no_ack", acks, 0);
      run_fetch(8'h20, 0, n, err, fd, a0, a1);
      check("midrst_refetch_latency", n, 6);
      check("midrst_refetch_data", fd, 16'hEAE3);

      reset = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h11; if_req = 1'b1; if_addr = 8'hFF;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      nack = 0; order = 4'd0; n = 0;
      while (nack < 4 && n < 200) begin
         @(negedge clk); n++;
         if (d_ack || if_ack) begin
            order = {order[2:0], if_ack};
            nack++;
         end
         if (nack == 4) begin d_req = 1'b0; if_req = 1'b0; end
      end
      d_req = 1'b0; if_req = 1'b0;
      check("arb_acks", nack, 4);
      check("arb_order", order, 4'b0101);
      check("arb_d_rdata", d_rdata, 8'h3C);
      check("arb_if_data", if_data, 16'h1234);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end

endmodule
